// File: rtl/aes_pkg.sv
// Shared AES datapath types and byte-addressing helpers.
package aes_pkg;

    localparam int STATE_W   = 128;
    localparam int NUM_BYTES = 16;

    typedef logic [STATE_W-1:0] state_t;
    typedef logic [7:0]         byte_t;

    // Column-major state layout: byte index of matrix element s[row][col].
    function automatic int byte_index(input int row, input int col);
        return row + 4 * col;
    endfunction

endpackage

// File: rtl/shift_rows_perm.sv
// Combinational ShiftRows (INVERSE=0) / InvShiftRows (INVERSE=1) byte permutation.
module shift_rows_perm
    import aes_pkg::*;
#(
    parameter bit INVERSE = 1'b0
) (
    input  state_t src,
    output state_t dst
);

    // Byte k sits at bits [127-8k -: 8]; row r rotates left (forward) or right (inverse) by r.
    for (genvar r = 0; r < 4; r++) begin : g_row
        for (genvar c = 0; c < 4; c++) begin : g_col
            localparam int SRC_COL = INVERSE ? ((c + 4 - r) % 4) : ((c + r) % 4);
            localparam int DST_BYTE = byte_index(r, c);
            localparam int SRC_BYTE = byte_index(r, SRC_COL);
            assign dst[STATE_W-1-8*DST_BYTE -: 8] = src[STATE_W-1-8*SRC_BYTE -: 8];
        end
    end

endmodule

// File: rtl/shift_rows_unit.sv
// Registered ShiftRows / InvShiftRows stage: two independent one-deep
// valid/ready channels, each permuting a 128-bit AES state with one cycle latency.
module shift_rows_unit
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,

    input  logic         fwd_valid_i,
    output logic         fwd_ready_o,
    input  logic [127:0] fwd_state_i,
    output logic         fwd_valid_o,
    input  logic         fwd_ready_i,
    output logic [127:0] fwd_state_o,

    input  logic         inv_valid_i,
    output logic         inv_ready_o,
    input  logic [127:0] inv_state_i,
    output logic         inv_valid_o,
    input  logic         inv_ready_i,
    output logic [127:0] inv_state_o
);

    state_t fwd_perm;
    state_t inv_perm;
    state_t fwd_state_p0;
    state_t inv_state_p0;
    logic   fwd_vld_p0;
    logic   inv_vld_p0;

    shift_rows_perm #(.INVERSE(1'b0)) u_fwd_perm (
        .src (fwd_state_i),
        .dst (fwd_perm)
    );

    shift_rows_perm #(.INVERSE(1'b1)) u_inv_perm (
        .src (inv_state_i),
        .dst (inv_perm)
    );

    // Single output register per channel: free when empty or when its content leaves this cycle.
    assign fwd_ready_o = !fwd_vld_p0 || fwd_ready_i;
    assign inv_ready_o = !inv_vld_p0 || inv_ready_i;

    // ---- stage p0: forward channel output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_vld_p0   <= 1'b0;
            fwd_state_p0 <= '0;
        end else if (fwd_ready_o) begin
            fwd_vld_p0 <= fwd_valid_i;
            if (fwd_valid_i) begin
                fwd_state_p0 <= fwd_perm;
            end
        end
    end

    // ---- stage p0: inverse channel output register ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inv_vld_p0   <= 1'b0;
            inv_state_p0 <= '0;
        end else if (inv_ready_o) begin
            inv_vld_p0 <= inv_valid_i;
            if (inv_valid_i) begin
                inv_state_p0 <= inv_perm;
            end
        end
    end

    assign fwd_valid_o = fwd_vld_p0;
    assign fwd_state_o = fwd_state_p0;
    assign inv_valid_o = inv_vld_p0;
    assign inv_state_o = inv_state_p0;

endmodule

// File: tb/tb_shift_rows_unit.sv
// Self-checking bench for shift_rows_unit: directed vectors, random round-trip,
// backpressure and asynchronous reset, against a row-rotation reference model.
module tb_shift_rows_unit;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         fwd_valid_i, fwd_ready_o, fwd_valid_o, fwd_ready_i;
    logic [127:0] fwd_state_i, fwd_state_o;
    logic         inv_valid_i, inv_ready_o, inv_valid_o, inv_ready_i;
    logic [127:0] inv_state_i, inv_state_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    shift_rows_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fwd_valid_i (fwd_valid_i),
        .fwd_ready_o (fwd_ready_o),
        .fwd_state_i (fwd_state_i),
        .fwd_valid_o (fwd_valid_o),
        .fwd_ready_i (fwd_ready_i),
        .fwd_state_o (fwd_state_o),
        .inv_valid_i (inv_valid_i),
        .inv_ready_o (inv_ready_o),
        .inv_state_i (inv_state_i),
        .inv_valid_o (inv_valid_o),
        .inv_ready_i (inv_ready_i),
        .inv_state_o (inv_state_o)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: unpack into a 4x4 matrix, rotate each row r by r places.
    function automatic logic [127:0] shift_ref(input logic [127:0] s, input bit inv);
        logic [7:0]   m [4][4];
        logic [127:0] o;
        int           sh;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                m[r][c] = s[127-8*(r+4*c) -: 8];
        o = '0;
        for (int r = 0; r < 4; r++) begin
            sh = inv ? (4 - r) % 4 : r;
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = m[r][(c+sh)%4];
        end
        return o;
    endfunction

    function automatic logic [127:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] x, xprev, x1, x2, inv_hold;

        rst_n       = 1'b0;
        fwd_valid_i = 1'b0;
        fwd_ready_i = 1'b1;
        fwd_state_i = '0;
        inv_valid_i = 1'b0;
        inv_ready_i = 1'b1;
        inv_state_i = '0;

        // Reset state
        #2;
        check("rst_fwd_valid", fwd_valid_o, 0);
        check("rst_fwd_state", fwd_state_o, 0);
        check("rst_fwd_ready", fwd_ready_o, 1);
        check("rst_inv_valid", inv_valid_o, 0);
        check("rst_inv_state", inv_state_o, 0);
        step();
        step();
        rst_n = 1'b1;

        // Directed ramp vectors, both channels in the same cycle
        fwd_valid_i = 1'b1;
        inv_valid_i = 1'b1;
        fwd_state_i = 128'h000102030405060708090a0b0c0d0e0f;
        inv_state_i = 128'h000102030405060708090a0b0c0d0e0f;
        step();
        check("ramp_fwd_valid", fwd_valid_o, 1);
        check("ramp_fwd", fwd_state_o, 128'h00050a0f04090e03080d02070c01060b);
        check("ramp_inv_valid", inv_valid_o, 1);
        check("ramp_inv", inv_state_o, 128'h000d0a0704010e0b0805020f0c090603);

        // FIPS-197 Appendix B round 1
        fwd_state_i = 128'hd42711aee0bf98f1b8b45de51e415230;
        inv_state_i = 128'hd4bf5d30e0b452aeb84111f11e2798e5;
        step();
        check("fips_fwd", fwd_state_o, 128'hd4bf5d30e0b452aeb84111f11e2798e5);
        check("fips_inv", inv_state_o, 128'hd42711aee0bf98f1b8b45de51e415230);

        // Random round-trip: forward result fed straight into inverse next cycle
        xprev = '0;
        for (int i = 0; i < 1000; i++) begin
            x = rand_state();
            fwd_state_i = x;
            fwd_valid_i = 1'b1;
            inv_valid_i = (i > 0);
            inv_state_i = fwd_state_o;
            check("rt_fwd_ready", fwd_ready_o, 1);
            check("rt_inv_ready", inv_ready_o, 1);
            step();
            check("rt_fwd_valid", fwd_valid_o, 1);
            check("rt_fwd", fwd_state_o, shift_ref(x, 1'b0));
            if (i > 0) begin
                check("rt_inv_valid", inv_valid_o, 1);
                check("rt_inv", inv_state_o, xprev);
                check("rt_inv_model", shift_ref(inv_state_i, 1'b1), xprev);
            end
            xprev = x;
        end

        // Idle inverse channel: register keeps its content, valid drops
        inv_hold    = inv_state_o;
        inv_valid_i = 1'b0;
        inv_state_i = rand_state();

        // Backpressure on forward channel
        x1 = rand_state();
        x2 = rand_state();
        fwd_state_i = x1;
        fwd_valid_i = 1'b1;
        step();
        check("idle_inv_valid", inv_valid_o, 0);
        check("idle_inv_state", inv_state_o, inv_hold);
        fwd_ready_i = 1'b0;
        fwd_state_i = x2;
        #1;
        check("bp_ready_low", fwd_ready_o, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_hold_state", fwd_state_o, shift_ref(x1, 1'b0));
            check("bp_hold_valid", fwd_valid_o, 1);
            check("bp_hold_ready", fwd_ready_o, 0);
        end
        fwd_ready_i = 1'b1;
        #1;
        check("bp_release_ready", fwd_ready_o, 1);
        step();
        check("bp_accept", fwd_state_o, shift_ref(x2, 1'b0));
        check("bp_accept_valid", fwd_valid_o, 1);

        // Asynchronous reset mid-cycle with a valid result held
        inv_valid_i = 1'b1;
        inv_state_i = rand_state();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_fwd_valid", fwd_valid_o, 0);
        check("arst_fwd_state", fwd_state_o, 0);
        check("arst_inv_valid", inv_valid_o, 0);
        check("arst_inv_state", inv_state_o, 0);
        step();
        check("arst_held_valid", fwd_valid_o, 0);
        #2;
        rst_n = 1'b1;
        x = rand_state();
        fwd_state_i = x;
        inv_state_i = x;
        step();
        check("recov_fwd_valid", fwd_valid_o, 1);
        check("recov_fwd", fwd_state_o, shift_ref(x, 1'b0));
        check("recov_inv", inv_state_o, shift_ref(x, 1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
